mask_bbox_overlay: RTL and testbench

Downstream consumer of the histogram-equalisation stage's 24-bit AXI-Stream (`[23:16]` saturation flag, `[15:8]` image mask, `[7:0]` original image). It tracks pixel coordinates from `tuser`/`tlast`, accumulates the bounding box of mask pixels and the count of saturated pixels per frame, and publishes both at each frame boundary. It also outputs the original image with the previous frame's bounding box drawn on it, for display.

---
 rtl/hist_eq_pkg.sv | 25 ++
 rtl/mask_bbox_overlay_if.sv | 15 +
 rtl/pixel_coord_counter.sv | 45 ++++
 rtl/mask_bbox_overlay.sv | 179 +++++++++++++++++
 tb/tb_mask_bbox_overlay.sv | 206 ++++++++++++++++++++
 5 files changed

// File: rtl/hist_eq_pkg.sv
// Shared definitions for the histogram-equalisation pipeline stages.
// Provides default widths, the channel layout of the 24-bit stage stream
// ([23:16] saturation, [15:8] mask, [7:0] original) and the bounding-box type.
package hist_eq_pkg;

  localparam int unsigned DATA_WIDTH_DEF  = 8;
  localparam int unsigned COORD_WIDTH_DEF = 12;

  // Channel slices inside the 3*DATA_WIDTH stream word
  localparam int unsigned ORIG_LO = 0;
  localparam int unsigned ORIG_HI = DATA_WIDTH_DEF - 1;
  localparam int unsigned MASK_LO = DATA_WIDTH_DEF;
  localparam int unsigned MASK_HI = 2 * DATA_WIDTH_DEF - 1;
  localparam int unsigned SAT_LO  = 2 * DATA_WIDTH_DEF;
  localparam int unsigned SAT_HI  = 3 * DATA_WIDTH_DEF - 1;

  typedef struct packed {
    logic [COORD_WIDTH_DEF-1:0] x_min;
    logic [COORD_WIDTH_DEF-1:0] x_max;
    logic [COORD_WIDTH_DEF-1:0] y_min;
    logic [COORD_WIDTH_DEF-1:0] y_max;
    logic                       valid;
  } bbox_t;

endpackage

// File: rtl/mask_bbox_overlay_if.sv
// AXI-Stream bundle used between pipeline stages.
// Ports (via modports): tdata[W], tvalid, tuser (start of frame),
// tlast (end of line), tready.
interface mask_bbox_overlay_if #(
  parameter int unsigned W = 24
) ();
  logic [W-1:0] tdata;
  logic         tvalid;
  logic         tuser;
  logic         tlast;
  logic         tready;

  modport master (output tdata, tvalid, tuser, tlast, input  tready);
  modport slave  (input  tdata, tvalid, tuser, tlast, output tready);
endinterface

// File: rtl/pixel_coord_counter.sv
// Tracks the (x,y) coordinate of each stream beat from tuser/tlast.
// Ports: i_sys_clk, i_sys_aresetn (async active-low), i_valid/i_user/i_last
// stream qualifiers; o_x_c/o_y_c coordinate of the current beat
// (combinational); o_first set until the first tuser beat after reset.
module pixel_coord_counter #(
  parameter int unsigned COORD_WIDTH = 12
) (
  input  logic                   i_sys_clk,
  input  logic                   i_sys_aresetn,
  input  logic                   i_valid,
  input  logic                   i_user,
  input  logic                   i_last,
  output logic [COORD_WIDTH-1:0] o_x_c,
  output logic [COORD_WIDTH-1:0] o_y_c,
  output logic                   o_first
);

  logic [COORD_WIDTH-1:0] r_x;
  logic [COORD_WIDTH-1:0] r_y;
  logic                   r_first;
  logic [COORD_WIDTH-1:0] w_x_inc;
  logic [COORD_WIDTH-1:0] w_y_inc;

  // A tuser beat is always pixel (0,0), whatever the running count says
  assign o_x_c   = i_user ? '0 : r_x;
  assign o_y_c   = i_user ? '0 : r_y;
  assign o_first = r_first;

  // Saturating increments: coordinates stick at all-ones instead of wrapping
  assign w_x_inc = (o_x_c == '1) ? o_x_c : o_x_c + COORD_WIDTH'(1);
  assign w_y_inc = (o_y_c == '1) ? o_y_c : o_y_c + COORD_WIDTH'(1);

  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_x     <= '0;
      r_y     <= '0;
      r_first <= 1'b1;
    end else if (i_valid) begin
      r_x <= i_last ? '0 : w_x_inc;
      r_y <= i_last ? w_y_inc : o_y_c;
      if (i_user) r_first <= 1'b0;
    end
  end

endmodule

// File: rtl/mask_bbox_overlay.sv
// Accumulates the bounding box of mask pixels and the saturated-pixel count
// per frame, publishes them at each frame boundary, and outputs the original
// image with the last published box drawn on it (2-cycle stream latency).
// Ports: i_sys_clk, i_sys_aresetn (async active-low); s_axis 24-bit input
// stream; m_axis DATA_WIDTH overlay stream; bbox_* / bbox_valid / sat_count
// last completed frame's results; frame_done pulses when those update.
module mask_bbox_overlay
  import hist_eq_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int unsigned           COORD_WIDTH = COORD_WIDTH_DEF,
  parameter logic [DATA_WIDTH-1:0] BOX_VALUE   = DATA_WIDTH'(8'hFF)
) (
  input  logic                     i_sys_clk,
  input  logic                     i_sys_aresetn,
  mask_bbox_overlay_if.slave       s_axis,
  mask_bbox_overlay_if.master      m_axis,
  output logic [COORD_WIDTH-1:0]   bbox_x_min,
  output logic [COORD_WIDTH-1:0]   bbox_x_max,
  output logic [COORD_WIDTH-1:0]   bbox_y_min,
  output logic [COORD_WIDTH-1:0]   bbox_y_max,
  output logic                     bbox_valid,
  output logic [2*COORD_WIDTH-1:0] sat_count,
  output logic                     frame_done
);

  localparam int unsigned BW = COORD_WIDTH_DEF;
  localparam int unsigned SW = 2 * COORD_WIDTH;
  localparam bbox_t ACC_INIT = '{x_min: '1, x_max: '0, y_min: '1, y_max: '0, valid: 1'b0};

  logic [COORD_WIDTH-1:0] w_x;
  logic [COORD_WIDTH-1:0] w_y;
  logic                   w_first;
  logic                   w_user;
  logic                   w_mask;
  logic                   w_sat;
  logic [BW-1:0]          w_xb;
  logic [BW-1:0]          w_yb;
  bbox_t                  w_acc_base;
  bbox_t                  w_acc_next;
  logic [SW-1:0]          w_sat_base;
  logic [SW-1:0]          w_sat_next;
  logic                   w_on_box;

  bbox_t                  r_acc;
  logic [SW-1:0]          r_acc_sat;
  bbox_t                  r_box;
  logic [SW-1:0]          r_sat_count;
  logic                   r_frame_done;
  logic                   r_tready;

  logic [DATA_WIDTH-1:0]  r_s1_pix;
  logic [COORD_WIDTH-1:0] r_s1_x;
  logic [COORD_WIDTH-1:0] r_s1_y;
  logic                   r_s1_valid;
  logic                   r_s1_user;
  logic                   r_s1_last;

  logic [DATA_WIDTH-1:0]  r_m_tdata;
  logic                   r_m_tvalid;
  logic                   r_m_tuser;
  logic                   r_m_tlast;

  pixel_coord_counter #(.COORD_WIDTH(COORD_WIDTH)) u_coord (
    .i_sys_clk     (i_sys_clk),
    .i_sys_aresetn (i_sys_aresetn),
    .i_valid       (s_axis.tvalid),
    .i_user        (s_axis.tuser),
    .i_last        (s_axis.tlast),
    .o_x_c         (w_x),
    .o_y_c         (w_y),
    .o_first       (w_first)
  );

  assign w_user = s_axis.tvalid & s_axis.tuser;
  assign w_mask = |s_axis.tdata[MASK_HI:MASK_LO];
  assign w_sat  = |s_axis.tdata[SAT_HI:SAT_LO];
  assign w_xb   = BW'(w_x);
  assign w_yb   = BW'(w_y);

  // Accumulator fold; a tuser beat restarts from the init values and still
  // contributes its own pixel to the new frame
  always_comb begin
    w_acc_base = w_user ? ACC_INIT : r_acc;
    w_sat_base = w_user ? '0 : r_acc_sat;
    w_acc_next = w_acc_base;
    w_sat_next = w_sat_base;
    if (w_mask) begin
      if (w_xb < w_acc_base.x_min) w_acc_next.x_min = w_xb;
      if (w_xb > w_acc_base.x_max) w_acc_next.x_max = w_xb;
      if (w_yb < w_acc_base.y_min) w_acc_next.y_min = w_yb;
      if (w_yb > w_acc_base.y_max) w_acc_next.y_max = w_yb;
      w_acc_next.valid = 1'b1;
    end
    if (w_sat && (w_sat_base != '1)) w_sat_next = w_sat_base + SW'(1);
  end

  // Accumulators and published results; first tuser after reset only opens
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_acc        <= '0;
      r_acc_sat    <= '0;
      r_box        <= '0;
      r_sat_count  <= '0;
      r_frame_done <= 1'b0;
      r_tready     <= 1'b0;
    end else begin
      r_tready     <= 1'b1;
      r_frame_done <= 1'b0;
      if (s_axis.tvalid) begin
        r_acc     <= w_acc_next;
        r_acc_sat <= w_sat_next;
      end
      if (w_user && !w_first) begin
        r_box        <= r_acc;
        r_sat_count  <= r_acc_sat;
        r_frame_done <= 1'b1;
      end
    end
  end

  // Overlay decision against the published box; the pixel in stage 1 at the
  // edge the box updates sees the new box, so a closing tuser pixel gets it
  always_comb begin
    logic [BW-1:0] xs;
    logic [BW-1:0] ys;
    logic          in_x;
    logic          in_y;
    xs       = BW'(r_s1_x);
    ys       = BW'(r_s1_y);
    in_x     = (xs >= r_box.x_min) && (xs <= r_box.x_max);
    in_y     = (ys >= r_box.y_min) && (ys <= r_box.y_max);
    w_on_box = r_box.valid &&
               ((((xs == r_box.x_min) || (xs == r_box.x_max)) && in_y) ||
                (((ys == r_box.y_min) || (ys == r_box.y_max)) && in_x));
  end

  // Two-stage stream pipeline, shifting every cycle
  always_ff @(posedge i_sys_clk or negedge i_sys_aresetn) begin
    if (!i_sys_aresetn) begin
      r_s1_pix   <= '0;
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_valid <= 1'b0;
      r_s1_user  <= 1'b0;
      r_s1_last  <= 1'b0;
      r_m_tdata  <= '0;
      r_m_tvalid <= 1'b0;
      r_m_tuser  <= 1'b0;
      r_m_tlast  <= 1'b0;
    end else begin
      r_s1_pix   <= s_axis.tdata[ORIG_HI:ORIG_LO];
      r_s1_x     <= w_x;
      r_s1_y     <= w_y;
      r_s1_valid <= s_axis.tvalid;
      r_s1_user  <= s_axis.tuser;
      r_s1_last  <= s_axis.tlast;
      r_m_tdata  <= w_on_box ? BOX_VALUE : r_s1_pix;
      r_m_tvalid <= r_s1_valid;
      r_m_tuser  <= r_s1_user;
      r_m_tlast  <= r_s1_last;
    end
  end

  assign s_axis.tready = r_tready;
  assign m_axis.tdata  = r_m_tdata;
  assign m_axis.tvalid = r_m_tvalid;
  assign m_axis.tuser  = r_m_tuser;
  assign m_axis.tlast  = r_m_tlast;

  assign bbox_x_min = COORD_WIDTH'(r_box.x_min);
  assign bbox_x_max = COORD_WIDTH'(r_box.x_max);
  assign bbox_y_min = COORD_WIDTH'(r_box.y_min);
  assign bbox_y_max = COORD_WIDTH'(r_box.y_max);
  assign bbox_valid = r_box.valid;
  assign sat_count  = r_sat_count;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_mask_bbox_overlay.sv
// Directed table-driven bench for mask_bbox_overlay.
module tb_mask_bbox_overlay;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  mask_bbox_overlay_if #(.W(24)) s_if ();
  mask_bbox_overlay_if #(.W(8))  m_if ();

  logic [11:0] bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max;
  logic        bbox_valid;
  logic [23:0] sat_count;
  logic        frame_done;

  mask_bbox_overlay dut (
    .i_sys_clk     (clk),
    .i_sys_aresetn (rstn),
    .s_axis        (s_if),
    .m_axis        (m_if),
    .bbox_x_min    (bbox_x_min),
    .bbox_x_max    (bbox_x_max),
    .bbox_y_min    (bbox_y_min),
    .bbox_y_max    (bbox_y_max),
    .bbox_valid    (bbox_valid),
    .sat_count     (sat_count),
    .frame_done    (frame_done)
  );

  typedef struct {
    logic        valid, user, last;
    logic [7:0]  sat, mask, orig, pix;
    logic        chk, chk_box;
    logic [11:0] x0, x1, y0, y1;
    logic        bv;
    logic [23:0] sc;
  } vec_t;

  vec_t vq[$];
  int   n_pass  = 0;
  int   n_total = 0;
  bit   seen    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t bt(input logic u, input logic l, input logic [7:0] s,
                              input logic [7:0] m, input logic [7:0] o, input logic [7:0] p);
    vec_t v;
    v.valid = 1'b1; v.user = u; v.last = l;
    v.sat = s; v.mask = m; v.orig = o; v.pix = p;
    v.chk = 1'b0; v.chk_box = 1'b0;
    v.x0 = '0; v.x1 = '0; v.y0 = '0; v.y1 = '0; v.bv = 1'b0; v.sc = '0;
    return v;
  endfunction

  function automatic vec_t idle();
    vec_t v;
    v = bt(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00);
    v.valid = 1'b0;
    return v;
  endfunction

  // Attach expected published status, checked right after this beat's edge
  function automatic vec_t st(input vec_t vi, input logic box, input logic [11:0] x0,
                              input logic [11:0] x1, input logic [11:0] y0,
                              input logic [11:0] y1, input logic bv, input logic [23:0] sc);
    vec_t v;
    v = vi;
    v.chk = 1'b1; v.chk_box = box;
    v.x0 = x0; v.x1 = x1; v.y0 = y0; v.y1 = y1; v.bv = bv; v.sc = sc;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    s_if.tvalid = v.valid;
    s_if.tuser  = v.user;
    s_if.tlast  = v.last;
    s_if.tdata  = {v.sat, v.mask, v.orig};
  endtask

  // Applies the queued beats plus one trailing idle; stream output is
  // compared against the beat applied one cycle earlier (2-edge latency)
  task automatic run_q();
    vec_t prev;
    bit   have;
    bit   exp_done;
    have = 1'b0;
    for (int i = 0; i <= vq.size(); i++) begin
      vec_t cur;
      if (i < vq.size()) cur = vq[i];
      else               cur = idle();
      drive(cur);
      @(posedge clk); #1;
      exp_done = cur.valid && cur.user && seen;
      if (cur.valid && cur.user) seen = 1'b1;
      check($sformatf("frame_done[%0d]", i), 64'(frame_done), 64'(exp_done));
      if (cur.chk) begin
        check($sformatf("bbox_valid[%0d]", i), 64'(bbox_valid), 64'(cur.bv));
        check($sformatf("sat_count[%0d]", i), 64'(sat_count), 64'(cur.sc));
        if (cur.chk_box)
          check($sformatf("bbox[%0d]", i), 64'({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max}),
                64'({cur.x0, cur.x1, cur.y0, cur.y1}));
      end
      if (have) begin
        check($sformatf("m_qual[%0d]", i - 1), 64'({m_if.tvalid, m_if.tuser, m_if.tlast}),
              64'({prev.valid, prev.user, prev.last}));
        if (prev.valid)
          check($sformatf("m_tdata[%0d]", i - 1), 64'(m_if.tdata), 64'(prev.pix));
      end
      prev = cur;
      have = 1'b1;
    end
    vq.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_tready"}, 64'(s_if.tready), 64'd0);
    check({tag, "_m"}, 64'({m_if.tvalid, m_if.tuser, m_if.tlast, m_if.tdata}), 64'd0);
    check({tag, "_bbox"}, 64'({bbox_x_min, bbox_x_max, bbox_y_min, bbox_y_max, bbox_valid}), 64'd0);
    check({tag, "_sat"}, 64'(sat_count), 64'd0);
    check({tag, "_done"}, 64'(frame_done), 64'd0);
  endtask

  initial begin
    drive(idle());
    m_if.tready = 1'b1;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    @(negedge clk) rstn = 1'b1;
    @(posedge clk); #1;
    check("tready_after_reset", 64'(s_if.tready), 64'd1);

    // Pre-tuser data: passed through, never published
    vq.push_back(bt(0, 0, 8'h00, 8'hFF, 8'd10, 8'd10));
    vq.push_back(bt(0, 1, 8'h00, 8'hFF, 8'd10, 8'd10));
    // Frame A 4x3: mask at (1,1),(2,2); sat at (0,0),(3,1),(2,2)
    vq.push_back(bt(1, 0, 8'h01, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 1, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'hFF, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 1, 8'h80, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'hFF, 8'hFF, 8'd10, 8'd10));
    vq.push_back(bt(0, 1, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(idle());
    // Frame B: closes A; box (1,2,1,2) drawn from its first pixel
    vq.push_back(st(bt(1, 0, 8'h00, 8'h00, 8'd10, 8'd10), 1, 12'd1, 12'd2, 12'd1, 12'd2, 1, 24'd3));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 1, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'hFF));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'hFF));
    vq.push_back(bt(0, 1, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'hFF));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'hFF));
    vq.push_back(bt(0, 1, 8'h00, 8'h00, 8'd10, 8'd10));
    // Frame C: single pixel with mask; closes B (no mask, no sat)
    vq.push_back(st(bt(1, 1, 8'h00, 8'hFF, 8'd10, 8'd10), 1, 12'hFFF, 12'd0, 12'hFFF, 12'd0, 0, 24'd0));
    // Frame D: closes C -> (0,0,0,0); next non-tuser pixel is (0,1)
    vq.push_back(st(bt(1, 1, 8'h00, 8'h00, 8'd10, 8'hFF), 1, 12'd0, 12'd0, 12'd0, 12'd0, 1, 24'd0));
    vq.push_back(bt(0, 0, 8'h00, 8'hFF, 8'd10, 8'd10));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd10, 8'd10));
    // Frame E: closes D -> (0,0,1,1)
    vq.push_back(st(bt(1, 0, 8'h00, 8'h00, 8'd20, 8'd20), 1, 12'd0, 12'd0, 12'd1, 12'd1, 1, 24'd0));
    vq.push_back(bt(0, 1, 8'h00, 8'h00, 8'd20, 8'd20));
    vq.push_back(bt(0, 0, 8'h00, 8'h00, 8'd20, 8'hFF));
    // Frame F: closes E (empty), then mask beats cut off by reset
    vq.push_back(st(bt(1, 0, 8'h00, 8'hFF, 8'd10, 8'd10), 1, 12'hFFF, 12'd0, 12'hFFF, 12'd0, 0, 24'd0));
    for (int k = 0; k < 4; k++) vq.push_back(bt(0, 0, 8'h00, 8'hFF, 8'd10, 8'd10));
    run_q();

    // Mid-frame asynchronous reset
    #2 rstn = 1'b0;
    #1;
    check_all_zero("midreset");
    repeat (2) @(posedge clk);
    @(negedge clk) rstn = 1'b1;
    seen = 1'b0;
    drive(idle());
    @(posedge clk); #1;
    check("tready_after_midreset", 64'(s_if.tready), 64'd1);

    // Frame G: first tuser publishes nothing; second closes G -> (1,1,0,0)
    vq.push_back(st(bt(1, 0, 8'h00, 8'h00, 8'd30, 8'd30), 1, 12'd0, 12'd0, 12'd0, 12'd0, 0, 24'd0));
    vq.push_back(st(bt(0, 1, 8'h00, 8'hFF, 8'd30, 8'd30), 1, 12'd0, 12'd0, 12'd0, 12'd0, 0, 24'd0));
    vq.push_back(st(bt(0, 0, 8'h00, 8'h00, 8'd30, 8'd30), 1, 12'd0, 12'd0, 12'd0, 12'd0, 0, 24'd0));
    vq.push_back(st(bt(1, 0, 8'h00, 8'h00, 8'd30, 8'd30), 1, 12'd1, 12'd1, 12'd0, 12'd0, 1, 24'd0));
    run_q();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
